alu_result_packer: RTL and testbench

Consumer side of the ALU result interface. Captures each registered ALU result (32-bit data plus its valid flag pulse) and emits it as a byte stream, LSB first, over a valid/ready handshake toward the TX FIFO/UART path. Holds one active result plus one pending result, so back-to-back ALU operations are not lost while the downstream stalls.

---
 rtl/alu_sys_pkg.sv | 29 ++
 rtl/alu_result_packer_if.sv | 25 ++
 rtl/alu_result_packer.sv | 133 +++++++++++++
 tb/tb_alu_result_packer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sys_pkg.sv
// Shared ALU-system constants and types: result/byte widths, the packer
// state encoding and the per-mode byte count.
package alu_sys_pkg;

    localparam int RES_WIDTH     = 32;
    localparam int BYTE_WIDTH    = 8;
    localparam int BYTES_PER_RES = RES_WIDTH / BYTE_WIDTH;
    localparam int NARROW_BYTES  = 2;
    localparam int CNT_WIDTH     = $clog2(BYTES_PER_RES) + 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    // Number of bytes emitted for a result, chosen by the wide flag
    function automatic cnt_t byte_count(input logic wide);
        cnt_t n;
        if (wide) begin
            n = cnt_t'(BYTES_PER_RES);
        end else begin
            n = cnt_t'(NARROW_BYTES);
        end
        return n;
    endfunction

endpackage

// File: rtl/alu_result_packer_if.sv
// ALU-result input strobe and byte-stream output handshake, bundled.
// master = ALU/downstream side, slave = the packer.
interface alu_result_packer_if
    import alu_sys_pkg::*;
#(
    parameter int RW = RES_WIDTH,
    parameter int BW = BYTE_WIDTH
);
    logic [RW-1:0] res_data;
    logic          res_valid;
    logic          res_wide;
    logic [BW-1:0] byte_out;
    logic          byte_valid;
    logic          byte_ready;

    modport master (
        output res_data, res_valid, res_wide, byte_ready,
        input  byte_out, byte_valid
    );

    modport slave (
        input  res_data, res_valid, res_wide, byte_ready,
        output byte_out, byte_valid
    );
endinterface

// File: rtl/alu_result_packer.sv
// Serialises registered ALU results into an LSB-first byte stream, with one
// active and one pending result so a second strobe survives a stalled sink.
module alu_result_packer
    import alu_sys_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    alu_result_packer_if.slave   bus,
    output logic                 busy,
    output logic                 overrun
);

    state_e                 state_q, state_d;
    logic [RES_WIDTH-1:0]   active_q, active_d;
    cnt_t                   count_q, count_d;
    logic [RES_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic                   pend_wide_q, pend_wide_d;
    logic                   pend_valid_q, pend_valid_d;
    logic [BYTE_WIDTH-1:0]  byte_out_q, byte_out_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   busy_q, busy_d;
    logic                   overrun_q, overrun_d;

    logic                   xfer_s;
    logic                   last_s;

    assign xfer_s = byte_valid_q & bus.byte_ready;
    assign last_s = xfer_s & (count_q == cnt_t'(1));

    // Next-state logic for the serializer, pending slot and output registers
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        count_d      = count_q;
        pend_data_d  = pend_data_q;
        pend_wide_d  = pend_wide_q;
        pend_valid_d = pend_valid_q;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.res_valid) begin
                    active_d = bus.res_data;
                    count_d  = byte_count(bus.res_wide);
                    state_d  = SEND;
                end else begin
                    state_d  = IDLE;
                end
            end
            SEND: begin
                if (xfer_s) begin
                    active_d = active_q >> BYTE_WIDTH;
                    count_d  = count_q - cnt_t'(1);
                end else begin
                    active_d = active_q;
                end

                // On the last byte the pending result takes priority; a
                // simultaneous strobe then refills the pending slot.
                if (last_s) begin
                    if (pend_valid_q) begin
                        active_d     = pend_data_q;
                        count_d      = byte_count(pend_wide_q);
                        pend_valid_d = bus.res_valid;
                        if (bus.res_valid) begin
                            pend_data_d = bus.res_data;
                            pend_wide_d = bus.res_wide;
                        end else begin
                            pend_data_d = pend_data_q;
                        end
                    end else if (bus.res_valid) begin
                        active_d = bus.res_data;
                        count_d  = byte_count(bus.res_wide);
                    end else begin
                        state_d  = IDLE;
                    end
                end else if (bus.res_valid) begin
                    if (!pend_valid_q) begin
                        pend_data_d  = bus.res_data;
                        pend_wide_d  = bus.res_wide;
                        pend_valid_d = 1'b1;
                    end else begin
                        overrun_d    = 1'b1;
                    end
                end else begin
                    pend_valid_d = pend_valid_q;
                end
            end
            default: begin
                state_d      = IDLE;
                pend_valid_d = 1'b0;
                count_d      = cnt_t'(0);
            end
        endcase

        byte_out_d   = active_d[BYTE_WIDTH-1:0];
        byte_valid_d = (state_d == SEND);
        busy_d       = byte_valid_d | pend_valid_d;
    end

    // State and output registers with asynchronous clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            active_q     <= {RES_WIDTH{1'b0}};
            count_q      <= cnt_t'(0);
            pend_data_q  <= {RES_WIDTH{1'b0}};
            pend_wide_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            byte_out_q   <= {BYTE_WIDTH{1'b0}};
            byte_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            count_q      <= count_d;
            pend_data_q  <= pend_data_d;
            pend_wide_q  <= pend_wide_d;
            pend_valid_q <= pend_valid_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.byte_out   = byte_out_q;
    assign bus.byte_valid = byte_valid_q;
    assign busy           = busy_q;
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_alu_result_packer.sv
// Self-checking bench for alu_result_packer: directed scenarios plus a
// randomized run against a byte-queue reference model.
module tb_alu_result_packer;

    logic clk = 1'b0;
    logic reset;
    logic busy;
    logic overrun;

    always #5 clk = ~clk;

    alu_result_packer_if #(.RW(32), .BW(8)) bus ();

    alu_result_packer dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: bytes still owed by the active result, one pending slot
    logic [7:0]  q_act[$];
    logic        pend_v;
    logic [31:0] pend_d;
    logic        pend_w;
    logic        exp_ovr;

    logic [7:0]  got[$];
    int          got_cyc[$];

    task automatic load_active(input logic [31:0] d, input logic w);
        q_act.delete();
        for (int i = 0; i < (w ? 4 : 2); i++) q_act.push_back(d[8*i +: 8]);
    endtask

    task automatic model_clear();
        q_act.delete();
        pend_v  = 1'b0;
        pend_d  = 32'd0;
        pend_w  = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic model_edge(input logic v, input logic [31:0] d, input logic w, input logic r);
        logic drop;
        drop = 1'b0;
        if (q_act.size() > 0 && r) void'(q_act.pop_front());
        if (q_act.size() == 0) begin
            if (pend_v) begin
                load_active(pend_d, pend_w);
                pend_v = v;
                if (v) begin pend_d = d; pend_w = w; end
            end else if (v) begin
                load_active(d, w);
            end
        end else if (v) begin
            if (!pend_v) begin pend_v = 1'b1; pend_d = d; pend_w = w; end
            else drop = 1'b1;
        end
        exp_ovr = drop;
    endtask

    // One clock: apply inputs at the falling edge, log transfers, advance model
    task automatic drive(input logic v, input logic [31:0] d, input logic w, input logic r);
        bus.res_valid  = v;
        bus.res_data   = d;
        bus.res_wide   = w;
        bus.byte_ready = r;
        if (bus.byte_valid === 1'b1 && r) begin
            got.push_back(bus.byte_out);
            got_cyc.push_back(cyc);
        end
        @(posedge clk);
        model_edge(v, d, w, r);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        n_tests++;
        if (bus.byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", bus.byte_valid); end
        n_tests++;
        if (bus.byte_out !== 8'h00) begin n_fail++; $display("FAIL reset_byte got %h exp 00", bus.byte_out); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    endtask

    task automatic test_wide();
        logic [7:0] exp_b[4];
        int s;
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        got.delete(); got_cyc.delete();
        s = cyc;
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_tests++;
        if (got.size() != 4) begin n_fail++; $display("FAIL wide_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i] || got_cyc[i] != s + 1 + i) begin
                n_fail++;
                $display("FAIL wide_byte%0d got %h@%0d exp %h@%0d", i, got[i], got_cyc[i], exp_b[i], s + 1 + i);
            end
        end
        n_tests++;
        if (bus.byte_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL wide_idle got valid=%b busy=%b exp 0/0", bus.byte_valid, busy);
        end
    endtask

    task automatic test_narrow();
        logic [7:0] exp_b[2];
        exp_b = '{8'hCD, 8'hAB};
        got.delete(); got_cyc.delete();
        drive(1'b1, 32'hFFFFABCD, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_tests++;
        if (got.size() != 2) begin n_fail++; $display("FAIL narrow_count got %0d exp 2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL narrow_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL narrow_idle busy got %b exp 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_b[4];
        exp_b = '{8'h78, 8'h56, 8'h34, 8'h12};
        got.delete(); got_cyc.delete();
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b0);
            n_tests++;
            if (bus.byte_valid !== 1'b1 || bus.byte_out !== 8'h56) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b %h exp v=1 56", i, bus.byte_valid, bus.byte_out);
            end
        end
        for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_tests++;
        if (got.size() != 4) begin n_fail++; $display("FAIL bp_count got %0d exp 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL bp_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b[8];
        int ovr_seen;
        exp_b = '{8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        ovr_seen = 0;
        got.delete(); got_cyc.delete();
        for (int i = 0; i < 14; i++) begin
            if (i == 0)      drive(1'b1, 32'h11223344, 1'b1, 1'b1);
            else if (i == 2) drive(1'b1, 32'hAABBCCDD, 1'b1, 1'b1);
            else             drive(1'b0, 32'd0, 1'b0, 1'b1);
            if (overrun === 1'b1) ovr_seen++;
        end
        n_tests++;
        if (got.size() != 8) begin n_fail++; $display("FAIL b2b_count got %0d exp 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i] || got_cyc[i] != got_cyc[0] + i) begin
                n_fail++; $display("FAIL b2b_byte%0d got %h@%0d exp %h@%0d", i, got[i], got_cyc[i], exp_b[i], got_cyc[0] + i);
            end
        end
        n_tests++;
        if (ovr_seen != 0) begin n_fail++; $display("FAIL b2b_overrun got %0d pulses exp 0", ovr_seen); end
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b[8];
        int ovr_seen;
        exp_b = '{8'h04, 8'h03, 8'h02, 8'h01, 8'h08, 8'h07, 8'h06, 8'h05};
        got.delete(); got_cyc.delete();
        drive(1'b1, 32'h01020304, 1'b1, 1'b0);
        drive(1'b1, 32'h05060708, 1'b1, 1'b0);
        n_tests++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b exp 0", overrun); end
        drive(1'b1, 32'h090A0B0C, 1'b1, 1'b0);
        n_tests++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
        ovr_seen = 0;
        drive(1'b0, 32'd0, 1'b0, 1'b0);
        if (overrun === 1'b1) ovr_seen++;
        for (int i = 0; i < 12; i++) begin
            drive(1'b0, 32'd0, 1'b0, 1'b1);
            if (overrun === 1'b1) ovr_seen++;
        end
        n_tests++;
        if (ovr_seen != 0) begin n_fail++; $display("FAIL ovr_width got %0d extra cycles exp 0", ovr_seen); end
        n_tests++;
        if (got.size() != 8) begin n_fail++; $display("FAIL ovr_count got %0d exp 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL ovr_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_b[2];
        exp_b = '{8'hEF, 8'hBE};
        got.delete(); got_cyc.delete();
        drive(1'b1, 32'h12345678, 1'b1, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        drive(1'b0, 32'd0, 1'b0, 1'b1);
        reset = 1'b0;
        #1;
        n_tests++;
        if (bus.byte_valid !== 1'b0 || bus.byte_out !== 8'h00 || busy !== 1'b0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got v=%b b=%h busy=%b ovr=%b exp all 0", bus.byte_valid, bus.byte_out, busy, overrun);
        end
        model_clear();
        @(negedge clk);
        reset = 1'b1;
        got.delete(); got_cyc.delete();
        drive(1'b1, 32'h0000BEEF, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) drive(1'b0, 32'd0, 1'b0, 1'b1);
        n_tests++;
        if (got.size() != 2) begin n_fail++; $display("FAIL rst_count got %0d exp 2", got.size()); end
        for (int i = 0; i < 2 && i < got.size(); i++) begin
            n_tests++;
            if (got[i] !== exp_b[i]) begin n_fail++; $display("FAIL rst_byte%0d got %h exp %h", i, got[i], exp_b[i]); end
        end
    endtask

    task automatic test_random();
        logic        v, w, r;
        logic [31:0] d;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 99) < 35);
            w = $urandom_range(0, 1);
            r = ($urandom_range(0, 99) < 65);
            d = $urandom;
            drive(v, d, w, r);
            n_tests++;
            if (bus.byte_valid !== (q_act.size() > 0)) begin
                n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", cyc, bus.byte_valid, q_act.size() > 0);
            end
            if (q_act.size() > 0) begin
                n_tests++;
                if (bus.byte_out !== q_act[0]) begin
                    n_fail++; $display("FAIL rnd_byte c%0d got %h exp %h", cyc, bus.byte_out, q_act[0]);
                end
            end
            n_tests++;
            if (busy !== ((q_act.size() > 0) || pend_v)) begin
                n_fail++; $display("FAIL rnd_busy c%0d got %b exp %b", cyc, busy, (q_act.size() > 0) || pend_v);
            end
            n_tests++;
            if (overrun !== exp_ovr) begin
                n_fail++; $display("FAIL rnd_overrun c%0d got %b exp %b", cyc, overrun, exp_ovr);
            end
        end
    endtask

    initial begin
        reset          = 1'b0;
        bus.res_valid  = 1'b0;
        bus.res_data   = 32'd0;
        bus.res_wide   = 1'b0;
        bus.byte_ready = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b1;
        @(negedge clk);
        test_wide();
        test_narrow();
        test_backpressure();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
